bus_ctrl_arbiter: RTL and testbench

Round-robin arbiter and transfer sequencer for the shared L1-to-L2 bus in the bus controller. Grants one of NUM_CPUS requesters exclusive ownership of the bus. Drives a BLOCK_SIZE_WORDS-beat block transfer to L2 using a per-beat ready handshake. Releases ownership on completion or on an L2 response timeout.

---
 rtl/bus_ctrl_arbiter.sv | 134 +++++++++++++
 tb/tb_bus_ctrl_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl_arbiter.sv
// Round-robin owner arbiter and block-transfer sequencer for the shared L1-to-L2 bus.
// One requester owns the bus for a full block, a timeout abort, or until reset.
module bus_ctrl_arbiter #(
    parameter int NUM_CPUS         = 2,
    parameter int BLOCK_SIZE_WORDS = 2,
    parameter int L2_TIMEOUT       = 25,
    localparam int IDW = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1,
    localparam int BW  = (BLOCK_SIZE_WORDS > 1) ? $clog2(BLOCK_SIZE_WORDS) : 1,
    localparam int WW  = $clog2(L2_TIMEOUT + 1)
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NUM_CPUS-1:0] req,
    input  logic [NUM_CPUS-1:0] req_rw,
    output logic [NUM_CPUS-1:0] gnt,
    output logic [IDW-1:0]      gnt_id,
    output logic                busy,
    output logic                l2_req,
    output logic                l2_rw,
    input  logic                l2_ready,
    output logic [BW-1:0]       beat_idx,
    output logic [NUM_CPUS-1:0] done,
    output logic                timeout_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [BW-1:0]  LAST_BEAT = BW'(BLOCK_SIZE_WORDS - 1);
    localparam logic [WW-1:0]  LAST_WAIT = WW'(L2_TIMEOUT - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_CPUS - 1);

    logic [1:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic           r_rw;
    logic           r_abort;
    logic [BW-1:0]  r_beat;
    logic [WW-1:0]  r_wait;

    logic           w_any;
    logic [IDW-1:0] w_win;

    // Rotating priority: first set request at or above r_ptr, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            int k;
            k = int'(r_ptr) + i;
            if (k >= NUM_CPUS) k = k - NUM_CPUS;
            if (!w_any && req[k]) begin
                w_any = 1'b1;
                w_win = IDW'(k);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_rw    <= 1'b0;
            r_abort <= 1'b0;
            r_beat  <= '0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_win;
                        r_rw    <= req_rw[w_win];
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (l2_ready) begin
                        r_wait <= '0;
                        if (r_beat == LAST_BEAT) begin
                            r_beat  <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end else if (r_wait == LAST_WAIT) begin
                        r_abort <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_ptr   <= (r_id == LAST_ID) ? '0 : r_id + 1'b1;
                    r_abort <= 1'b0;
                    r_beat  <= '0;
                    r_wait  <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt         = '0;
        gnt_id      = '0;
        busy        = 1'b0;
        l2_req      = 1'b0;
        l2_rw       = 1'b0;
        beat_idx    = '0;
        done        = '0;
        timeout_err = 1'b0;
        case (r_state)
            ST_XFER: begin
                gnt[r_id] = 1'b1;
                gnt_id    = r_id;
                busy      = 1'b1;
                l2_req    = 1'b1;
                l2_rw     = r_rw;
                beat_idx  = r_beat;
            end
            ST_DONE: begin
                gnt_id      = r_id;
                busy        = 1'b1;
                done[r_id]  = 1'b1;
                timeout_err = r_abort;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_ctrl_arbiter.sv
// Directed bench for bus_ctrl_arbiter with default parameters (2 CPUs, 2 beats,
// timeout 25). Outputs packed as {gnt,gnt_id,busy,l2_req,l2_rw,beat_idx,done,timeout_err}.
module tb_bus_ctrl_arbiter;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] req_rw = '0;
    logic [1:0] gnt;
    logic       gnt_id;
    logic       busy;
    logic       l2_req;
    logic       l2_rw;
    logic       l2_ready = 1'b0;
    logic       beat_idx;
    logic [1:0] done;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    bus_ctrl_arbiter #(
        .NUM_CPUS(2),
        .BLOCK_SIZE_WORDS(2),
        .L2_TIMEOUT(25)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .req(req),
        .req_rw(req_rw),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .busy(busy),
        .l2_req(l2_req),
        .l2_rw(l2_rw),
        .l2_ready(l2_ready),
        .beat_idx(beat_idx),
        .done(done),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       n;
        logic [1:0] rq;
        logic [1:0] rw;
        logic       rdy;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [9:0] ZERO = 10'b0;

    function automatic logic [9:0] xf(logic id, logic rw, logic bt);
        logic [1:0] g;
        g = id ? 2'b10 : 2'b01;
        return {g, id, 1'b1, 1'b1, rw, bt, 2'b00, 1'b0};
    endfunction

    function automatic logic [9:0] dn(logic id, logic to);
        logic [1:0] d;
        d = id ? 2'b10 : 2'b01;
        return {2'b00, id, 1'b1, 1'b0, 1'b0, 1'b0, d, to};
    endfunction

    function automatic logic [9:0] outs();
        return {gnt, gnt_id, busy, l2_req, l2_rw, beat_idx, done, timeout_err};
    endfunction

    task automatic add(logic n, logic [1:0] rq, logic [1:0] rw,
                       logic rdy, logic [9:0] exp);
        vec_t v;
        v.n = n; v.rq = rq; v.rw = rw; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(string name, logic [9:0] exp);
        logic [9:0] act;
        act = outs();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
        total++;
        if ((l2_req !== (|gnt)) || ($countones(gnt) > 1) || ($countones(done) > 1)) begin
            bad++;
            $display("FAIL %s invariant: gnt=%b done=%b l2_req=%b", name, gnt, done, l2_req);
        end
    endtask

    task automatic drive(logic n, logic [1:0] rq, logic [1:0] rw, logic rdy);
        nRST = n; req = rq; req_rw = rw; l2_ready = rdy;
    endtask

    initial begin
        int cyc;

        // reset
        add(0, 2'b00, 2'b00, 0, ZERO);
        add(0, 2'b00, 2'b00, 0, ZERO);
        // single request from CPU0
        add(1, 2'b01, 2'b00, 1, xf(0, 0, 0));
        add(1, 2'b01, 2'b00, 1, xf(0, 0, 1));
        add(1, 2'b01, 2'b00, 1, dn(0, 0));
        add(1, 2'b00, 2'b00, 1, ZERO);
        // reset, then both request: grants 0,1,0
        add(0, 2'b00, 2'b00, 0, ZERO);
        add(1, 2'b11, 2'b10, 1, xf(0, 0, 0));
        add(1, 2'b11, 2'b10, 1, xf(0, 0, 1));
        add(1, 2'b11, 2'b10, 1, dn(0, 0));
        add(1, 2'b11, 2'b10, 1, ZERO);
        add(1, 2'b11, 2'b10, 1, xf(1, 1, 0));
        add(1, 2'b11, 2'b10, 1, xf(1, 1, 1));
        add(1, 2'b11, 2'b10, 1, dn(1, 0));
        add(1, 2'b11, 2'b10, 1, ZERO);
        add(1, 2'b11, 2'b10, 1, xf(0, 0, 0));
        add(1, 2'b11, 2'b10, 1, xf(0, 0, 1));
        add(1, 2'b11, 2'b10, 1, dn(0, 0));
        add(1, 2'b00, 2'b00, 1, ZERO);
        // CPU1 owns; drops req while CPU0 raises req: no preemption
        add(1, 2'b10, 2'b10, 0, xf(1, 1, 0));
        add(1, 2'b01, 2'b00, 1, xf(1, 1, 1));
        add(1, 2'b01, 2'b00, 1, dn(1, 0));
        add(1, 2'b01, 2'b00, 1, ZERO);
        add(1, 2'b01, 2'b00, 1, xf(0, 0, 0));
        add(1, 2'b01, 2'b00, 1, xf(0, 0, 1));
        // reset during beat 1: no done, pending req regranted
        add(0, 2'b01, 2'b00, 1, ZERO);
        add(1, 2'b01, 2'b00, 0, xf(0, 0, 0));
        add(1, 2'b01, 2'b00, 1, xf(0, 0, 1));
        add(1, 2'b00, 2'b00, 1, dn(0, 0));
        add(1, 2'b00, 2'b00, 1, ZERO);

        foreach (vecs[i]) begin
            drive(vecs[i].n, vecs[i].rq, vecs[i].rw, vecs[i].rdy);
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // beat stall: 3 idle cycles before each beat
        drive(0, 2'b00, 2'b00, 0); tick(); check("stall_rst", ZERO);
        drive(1, 2'b01, 2'b01, 0); tick(); check("stall_gnt", xf(0, 1, 0));
        for (int i = 0; i < 3; i++) begin
            tick(); check($sformatf("stall_b0_%0d", i), xf(0, 1, 0));
        end
        l2_ready = 1; tick(); check("stall_beat1", xf(0, 1, 1));
        l2_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); check($sformatf("stall_b1_%0d", i), xf(0, 1, 1));
        end
        l2_ready = 1; tick(); check("stall_done", dn(0, 0));
        drive(1, 2'b00, 2'b00, 0); tick(); check("stall_idle", ZERO);

        // timeout on CPU1 (rr_ptr now 1)
        drive(1, 2'b10, 2'b00, 0); tick(); check("to_gnt", xf(1, 0, 0));
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done != 2'b00) begin
                cyc = i;
                break;
            end
        end
        total++;
        if (cyc != 25) begin
            bad++;
            $display("FAIL to_latency: got %0d cycles want 25", cyc);
        end
        check("to_done", dn(1, 1));
        // after abort, rr_ptr=0: CPU0 wins with both requesting
        drive(1, 2'b11, 2'b00, 1); tick(); check("to_idle", ZERO);
        tick(); check("to_next", xf(0, 0, 0));
        drive(0, 2'b00, 2'b00, 0); tick(); check("final_rst", ZERO);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
